// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, 2-flop row sync, press/release debounce.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
//
// state    | meaning
// SCAN     | strobing columns, sampling rows on the last dwell cycle
// DEBOUNCE | hit latched, counting consecutive low samples of the latched row
// HELD     | press accepted, waiting for the latched row to go high
// RELEASE  | counting consecutive high samples before resuming the scan
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int REPEAT_CNT   = 5000000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Code,
  output logic       Valid
);

  localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         col_idx, col_nxt;
  logic [1:0]         row_idx, row_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic [DEB_W-1:0]   deb_cnt, deb_nxt;
  logic [3:0]         code_q, code_nxt;
  logic               valid_q, valid_nxt;
  logic [3:0]         row_s1, row_sync;
  logic               row_hit;
  logic [1:0]         hit_idx;
  logic               row_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CNT + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CNT - 1);
  logic [RPT_W-1:0] rpt_cnt, rpt_nxt;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      row_s1   <= 4'h0;
      row_sync <= 4'h0;
    end else begin
      row_s1   <= Row;
      row_sync <= row_s1;
    end
  end

  // Lowest-index low row wins when several are pressed in the same column.
  always_comb begin
    row_hit = 1'b0;
    hit_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) begin
        row_hit = 1'b1;
        hit_idx = 2'(r);
      end
    end
  end

  assign row_low = ~row_sync[row_idx];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      row_idx   <= row_nxt;
      dwell_cnt <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      code_q    <= code_nxt;
      valid_q   <= valid_nxt;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= rpt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    row_nxt   = row_idx;
    dwell_nxt = dwell_cnt;
    deb_nxt   = deb_cnt;
    code_nxt  = code_q;
    valid_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_nxt   = rpt_cnt;
`endif
    case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          if (row_hit) begin
            row_nxt   = hit_idx;
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          col_nxt   = col_idx + 2'd1;
          state_nxt = SCAN;
        end else if (deb_cnt == DEB_LAST) begin
          valid_nxt = 1'b1;
          code_nxt  = {row_idx, col_idx};
          deb_nxt   = '0;
          state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!row_low) begin
          deb_nxt   = '0;
          state_nxt = RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rpt_cnt == RPT_LAST) begin
          valid_nxt = 1'b1;
          rpt_nxt   = '0;
        end else begin
          rpt_nxt = rpt_cnt + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (row_low) begin
          deb_nxt   = '0;
          state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end else if (deb_cnt == DEB_LAST) begin
          deb_nxt   = '0;
          col_nxt   = col_idx + 2'd1;
          state_nxt = SCAN;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  assign Col   = ~(4'b0001 << col_idx);
  assign Code  = code_q;
  assign Valid = valid_q;

endmodule
